// File: rtl/result_streamer.sv
// result_streamer
//   Streams an N*N result matrix out of the upstream output SRAM as a
//   valid/ready beat stream once collection_complete_i rises. Reads are
//   issued in address order, land in a small FIFO, and are presented from
//   registered FIFO state. Read issue is credit-limited so the FIFO can
//   never overflow.
//
// Ports
//   clk_i, rstn_i             clock, async active-low reset
//   collection_complete_i     matrix ready upstream (rising edge starts a stream)
//   clear_i                   synchronous abort/flush
//   sram_read_enable_o/addr_o read request to the output SRAM
//   sram_read_data_i/valid_i  read response, fixed 1-cycle latency
//   m_valid_o/data_o/last_o   output stream, m_ready_i from downstream
//   busy_o, done_o, error_o   status: not idle, end-of-stream pulse, sticky error
module result_streamer #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       collection_complete_i,
  input  logic                       clear_i,
  output logic                       sram_read_enable_o,
  output logic [$clog2(N*N)-1:0]     sram_read_addr_o,
  input  logic [DATA_WIDTH-1:0]      sram_read_data_i,
  input  logic                       sram_read_valid_i,
  output logic                       m_valid_o,
  output logic [DATA_WIDTH-1:0]      m_data_o,
  output logic                       m_last_o,
  input  logic                       m_ready_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       error_o
);

  localparam int NN = N * N;
  localparam int AW = $clog2(NN);
  localparam int CW = AW + 1;                       // holds NN without wrapping
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t          state;
  logic            cc_q;        // previous collection_complete_i
  logic [CW-1:0]   addr_cnt;
  logic            out_q;       // a read was issued last cycle; response due now
  logic [AW-1:0]   out_addr;    // address of that read
  logic            drop_q;      // response due now belongs to a cleared stream

  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] fifo_data;
  logic [FIFO_DEPTH-1:0]                 fifo_last;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [OW-1:0]   occ;

  logic rise, pop, full, credit_ok, read_en, rsp, push, err_ev;
  logic [OW:0] need_w, room_w;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rise = collection_complete_i & ~cc_q;
  assign pop  = m_valid_o & m_ready_i;
  assign full = (occ == OW'(FIFO_DEPTH));

  // Credit: entries held + the response arriving now, less the beat leaving
  // now, must leave room for the read issued this cycle. Using this cycle's
  // pop lets the stream sustain one beat per cycle with only two entries.
  assign need_w    = {1'b0, occ} + {{OW{1'b0}}, out_q};
  assign room_w    = (OW+1)'(FIFO_DEPTH) + {{OW{1'b0}}, pop};
  assign credit_ok = need_w < room_w;
  assign read_en   = (state == STREAM) & (addr_cnt < CW'(NN)) & credit_ok;

  assign sram_read_enable_o = read_en;
  assign sram_read_addr_o   = addr_cnt[AW-1:0];

  // A response with nothing outstanding, or into a full FIFO, is dropped and
  // flagged. The response to a read issued in the clear cycle is silently ignored.
  assign rsp    = sram_read_valid_i & ~drop_q;
  assign push   = rsp & out_q & ~full;
  assign err_ev = rsp & (~out_q | full);

  assign m_valid_o = (occ != '0);
  assign m_data_o  = fifo_data[rd_ptr];
  assign m_last_o  = m_valid_o & fifo_last[rd_ptr];
  assign busy_o    = (state != IDLE);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      cc_q     <= 1'b0;
      addr_cnt <= '0;
      out_q    <= 1'b0;
      out_addr <= '0;
      drop_q   <= 1'b0;
      done_o   <= 1'b0;
      error_o  <= 1'b0;
    end else begin
      cc_q   <= collection_complete_i;
      drop_q <= clear_i;
      done_o <= 1'b0;
      if (clear_i) begin
        state    <= IDLE;
        addr_cnt <= '0;
        out_q    <= 1'b0;
        error_o  <= 1'b0;
      end else begin
        out_q <= read_en;
        if (read_en) begin
          out_addr <= addr_cnt[AW-1:0];
          addr_cnt <= addr_cnt + 1'b1;
        end
        if (err_ev) error_o <= 1'b1;
        case (state)
          IDLE: if (rise) begin
            state    <= STREAM;
            addr_cnt <= '0;
          end
          STREAM: if (pop && m_last_o) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fifo_data <= '0;
      fifo_last <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= sram_read_data_i;
        fifo_last[wr_ptr] <= (out_addr == AW'(NN - 1));
        wr_ptr            <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      occ <= occ + OW'(push) - OW'(pop);
    end
  end

endmodule

// File: tb/tb_result_streamer.sv
// tb_result_streamer
//   Randomized-backpressure bench for result_streamer (N=4, FIFO_DEPTH=2).
//   An SRAM model answers reads with addr+100 one cycle later; a queue of
//   expected beats per stream is the reference for order, data and last.
module tb_result_streamer;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int FD = 2;
  localparam int NN = N * N;
  localparam int AW = $clog2(NN);

  logic          clk, rstn, cc, clear;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          m_valid, m_last, m_ready;
  logic [DW-1:0] m_data;
  logic          busy, done, error;

  result_streamer #(.N(N), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .collection_complete_i(cc), .clear_i(clear),
    .sram_read_enable_o(rd_en), .sram_read_addr_o(rd_addr),
    .sram_read_data_i(rd_data), .sram_read_valid_i(rd_valid),
    .m_valid_o(m_valid), .m_data_o(m_data), .m_last_o(m_last), .m_ready_i(m_ready),
    .busy_o(busy), .done_o(done), .error_o(error)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: fixed 1-cycle read latency, contents addr+100
  logic inject = 0;
  always @(posedge clk) begin
    rd_valid <= (rd_en && rstn) || inject;
    rd_data  <= DW'(rd_addr) + 100;
  end

  // ready driver: 0 = always high, 1 = 1 high / 2 low, 2 = random
  int rmode = 0, rpct = 50, ph = 0;
  initial begin
    m_ready = 1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: m_ready = 1;
        1: begin m_ready = (ph == 0); ph = (ph + 1) % 3; end
        default: m_ready = ($urandom_range(99) < rpct);
      endcase
    end
  end

  // reference model + monitor
  logic [DW-1:0] exp_q[$];
  int  exp_rd, issued, accepted, dones, done_total;
  int  first_rd, first_vld, last_acc, done_c;
  bit  mon_en = 0, stall_q = 0, hold_l;
  logic [DW-1:0] hold_d, e;

  always @(negedge clk) begin
    if (done) done_total++;
    if (rstn && mon_en) begin
      if (rd_en) begin
        chk("rd_addr", rd_addr, exp_rd);
        if (first_rd < 0) first_rd = cyc;
        exp_rd++;
        issued++;
      end
      if (stall_q) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, hold_d);
        chk("hold_last", m_last, hold_l);
      end
      if (m_valid && first_vld < 0) first_vld = cyc;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat_data", m_data, e);
          chk("beat_last", m_last, exp_q.size() == 0);
        end
        accepted++;
        if (m_last) last_acc = cyc;
      end
      chk("credit", (issued - accepted) <= FD, 1);
      if (done) begin
        dones++;
        if (done_c < 0) done_c = cyc;
      end
      stall_q = m_valid && !m_ready;
      hold_d  = m_data;
      hold_l  = m_last;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_test();
    exp_q.delete();
    for (int i = 0; i < NN; i++) exp_q.push_back(DW'(i + 100));
    exp_rd = 0; issued = 0; accepted = 0; dones = 0;
    first_rd = -1; first_vld = -1; last_acc = -1; done_c = -1;
    stall_q = 0;
    mon_en = 1;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (dones == 0 && n < budget) begin step(); n++; end
    if (dones == 0) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic end_checks(input string tag);
    step(3);
    chk({tag, "_beats"}, accepted, NN);
    chk({tag, "_dones"}, dones, 1);
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_err"}, error, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_data"}, m_data, 0);
    chk({tag, "_last"}, m_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  initial begin
    int set_c, n, d0;
    rstn = 0; cc = 0; clear = 0;
    step(3);
    chk_zero("rst");
    rstn = 1;
    step(2);

    // full-rate stream and latency
    rmode = 0;
    start_test();
    cc = 1; set_c = cyc;
    wait_done(200, "rate");
    chk("t_first_rd", first_rd, set_c + 1);
    chk("t_first_vld", first_vld, set_c + 3);
    chk("t_last_acc", last_acc, set_c + NN + 2);
    chk("t_done", done_c, set_c + NN + 3);
    cc = 0;
    end_checks("rate");

    // fixed backpressure 1 high / 2 low
    rmode = 1; ph = 0;
    start_test();
    cc = 1;
    wait_done(400, "bp");
    cc = 0;
    end_checks("bp");

    // random backpressure
    rmode = 2;
    for (int r = 0; r < 4; r++) begin
      rpct = $urandom_range(90, 20);
      start_test();
      cc = 1;
      wait_done(800, "rnd");
      cc = 0;
      end_checks("rnd");
    end

    // level held high must not retrigger
    rmode = 0;
    start_test();
    cc = 1;
    step(40);
    cc = 0;
    step(5);
    chk("hold_reads", issued, NN);
    end_checks("hold");

    // clear mid-stream with a read in flight
    start_test();
    cc = 1;
    n = 0;
    while (accepted < 5 && n < 100) begin step(); n++; end
    chk("clr_reach5", accepted >= 5, 1);
    mon_en = 0;
    chk("clr_rd_inflight", rd_en, 1);
    clear = 1;
    step();
    clear = 0;
    chk("clr_valid", m_valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_err", error, 0);
    step(3);
    chk("clr_err_late", error, 0);
    chk("clr_noretrig", busy, 0);
    cc = 0;
    step();
    start_test();
    cc = 1;
    wait_done(200, "restart");
    cc = 0;
    end_checks("restart");

    // stray response in IDLE
    inject = 1;
    step();
    inject = 0;
    step(2);
    chk("inj_err", error, 1);
    step(5);
    chk("inj_sticky", error, 1);
    clear = 1;
    step();
    clear = 0;
    chk("inj_clr", error, 0);

    // async reset mid-stream, collection_complete_i kept high across it
    start_test();
    cc = 1;
    n = 0;
    while (accepted < 3 && n < 100) begin step(); n++; end
    mon_en = 0;
    d0 = done_total;
    #2 rstn = 0;
    #1 chk_zero("arst");
    step(3);
    chk("arst_nodone", done_total, d0);
    start_test();
    rstn = 1;
    wait_done(200, "post_rst");
    end_checks("post_rst");
    cc = 0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/result_streamer.md
RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001 Parameter N, default 8: systolic array dimension; the result matrix holds N*N words.
REQ-002 Parameter DATA_WIDTH, default 32: width of one result word.
REQ-003 Parameter FIFO_DEPTH, default 2: output FIFO entries; minimum 2.
REQ-004 clk_i  in  1: single clock; all logic on its rising edge.
REQ-005 rstn_i  in  1: reset; asynchronous assertion, active-low.
REQ-006 collection_complete_i  in  1: result matrix fully collected in the upstream output SRAM.
REQ-007 clear_i  in  1: synchronous abort/flush.
REQ-008 sram_read_enable_o  out  1: read request to the output SRAM.
REQ-009 sram_read_addr_o  out  $clog2(N*N): read address.
REQ-010 sram_read_data_i  in  DATA_WIDTH: read data.
REQ-011 sram_read_valid_i  in  1: read data valid, fixed 1 cycle after sram_read_enable_o.
REQ-012 m_valid_o  out  1: output stream beat valid.
REQ-013 m_data_o  out  DATA_WIDTH: output stream data.
REQ-014 m_last_o  out  1: marks the beat for address N*N-1.
REQ-015 m_ready_i  in  1: downstream ready.
REQ-016 busy_o  out  1: high in every state except IDLE.
REQ-017 done_o  out  1: one-cycle pulse after the last beat is accepted.
REQ-018 error_o  out  1: sticky protocol error.

Function
REQ-019 FSM states SHALL be IDLE, STREAM, DONE. Transitions:
- IDLE->STREAM on a rising edge of collection_complete_i (input high, registered previous value low).
- STREAM->DONE on handshake of the m_last_o beat.
- DONE->IDLE unconditionally after 1 cycle.
REQ-020 Rising edges of collection_complete_i outside IDLE SHALL be ignored; a level held high SHALL NOT retrigger.
REQ-021 On entering STREAM, the read address counter SHALL be 0; addresses SHALL be issued strictly in order 0..N*N-1, each exactly once.
REQ-022 A read SHALL issue in STREAM only when addr_count < N*N and (fifo_occupancy + outstanding - pop_this_cycle) < FIFO_DEPTH.
- This guarantees no overflow.
- Outstanding is at most 1.
REQ-023 Data SHALL be written to the FIFO on sram_read_valid_i and presented registered: m_valid_o rises the cycle after sram_read_valid_i.
REQ-024 m_data_o and m_last_o SHALL hold stable while m_valid_o=1 and m_ready_i=0.
REQ-025 A beat SHALL transfer only on m_valid_o & m_ready_i.
REQ-026 m_last_o SHALL be high only with the beat carrying address N*N-1.
REQ-027 Latency: with the edge sampled at cycle T, sram_read_enable_o SHALL be high at T+1 (addr 0), m_valid_o at T+3.
REQ-028 With m_ready_i held high, throughput SHALL be 1 beat/cycle, and the last beat SHALL be accepted at T+N*N+2.
REQ-029 sram_read_valid_i asserted with no read outstanding, or with the FIFO full, SHALL set error_o and the data SHALL be dropped.
REQ-030 clear_i SHALL, in any state, at the next edge:
- return the FSM to IDLE;
- empty the FIFO and zero the counters;
- deassert m_valid_o;
- discard a read returning in the following cycle without setting error_o;
- clear error_o;
- not pulse done_o.
REQ-031 clear_i coincident with a collection_complete_i rising edge SHALL take priority; the edge SHALL be ignored.
REQ-032 Address counter width SHALL be $clog2(N*N)+1 so that the value N*N is representable without wrap.

Reset
REQ-033 While rstn_i=0, the following outputs SHALL be 0: sram_read_enable_o, sram_read_addr_o, m_valid_o, m_data_o, m_last_o, busy_o, done_o, error_o.
REQ-034 While rstn_i=0, the FSM SHALL be IDLE, the FIFO empty, and the edge-detect register 0.
REQ-035 Reset asserted mid-STREAM SHALL abort immediately, with no done_o pulse.
REQ-036 After reset, a collection_complete_i already high SHALL count as a rising edge.

Verification
REQ-037 N=4, SRAM holds value = addr+100, ready always 1.
- Expected: 16 beats 100..115, consecutive cycles.
- Expected: m_last_o on 115, done_o at T+19.
REQ-038 Backpressure: ready toggles 1 cycle high / 2 cycles low.
- Expected: all 16 beats in order, no loss or duplication.
- Expected: data stable while stalled.
- Expected: sram_read_enable_o never exceeds FIFO_DEPTH credits.
REQ-039 collection_complete_i held high 40 cycles.
- Expected: exactly one 16-beat stream and one done_o.
REQ-040 clear_i after beat 5 accepted while a read is in flight.
- Expected: m_valid_o low next cycle; error_o stays 0.
- Expected: a new edge restarts at address 0.
REQ-041 Inject sram_read_valid_i in IDLE.
- Expected: error_o=1 until clear_i.
REQ-042 Drop rstn_i mid-stream.
- Expected: all outputs 0 asynchronously, no done_o.
